// File: rtl/espiro_ctrl_if.sv
// Purpose : signal bundle between the spirometer window controller and its host.
// Ports   : slave  - controller side (takes start/abort/samples, drives the
//                    comparator outputs and status).
//           master - host/bench side (mirror of slave).
interface espiro_ctrl_if;
    localparam int unsigned SMP_W   = 10;
    localparam int unsigned SUM_W   = 14;
    localparam int unsigned CVP_W   = 10;
    localparam int unsigned STATE_W = 3;

    logic               iStart;
    logic               iAbort;
    logic               iSampleValid;
    logic [SMP_W-1:0]   ivSample;
    logic [SUM_W-1:0]   ovSuma;
    logic [CVP_W-1:0]   ovCVP;
    logic               oCE;
    logic               oBusy;
    logic               oCalDone;
    logic               oDone;
    logic [STATE_W-1:0] ovState;

    modport slave (
        input  iStart, iAbort, iSampleValid, ivSample,
        output ovSuma, ovCVP, oCE, oBusy, oCalDone, oDone, ovState
    );

    modport master (
        output iStart, iAbort, iSampleValid, ivSample,
        input  ovSuma, ovCVP, oCE, oBusy, oCalDone, oDone, ovState
    );
endinterface

// File: rtl/espiro_ctrl.sv
// Purpose : spirometer measurement controller. Sums ADC flow samples into
//           fixed-size windows, calibrates a per-level step (CVP) from the peak
//           window of a calibration phase, then strobes a comparator once per
//           measurement window until the flow goes quiet or a timeout expires.
// Ports   : iClk      - clock, all state on rising edge
//           iReset_n  - asynchronous active-low reset
//           bus       - espiro_ctrl_if.slave (start/abort/samples in,
//                       window sum, CVP, comparator strobe and status out)
module espiro_ctrl #(
    parameter int unsigned N_SAMPLES     = 16,
    parameter int unsigned CAL_WINDOWS   = 4,
    parameter int unsigned QUIET_WINDOWS = 2,
    parameter int unsigned MAX_WINDOWS   = 1023
) (
    input  logic         iClk,
    input  logic         iReset_n,
    espiro_ctrl_if.slave bus
);
    localparam int unsigned SUM_W   = 14;
    localparam int unsigned CVP_W   = 10;
    localparam int unsigned SCNT_W  = 4;
    localparam int unsigned WCNT_W  = 10;
    localparam int unsigned QCNT_W  = 4;
    localparam int unsigned PROD_W  = 18;
    localparam int unsigned CVPR_W  = 11;
    localparam int unsigned CVP_MUL = 13;
    localparam int unsigned CVP_SHR = 7;

    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(N_SAMPLES - 1);
    localparam logic [WCNT_W-1:0] LAST_CAL    = WCNT_W'(CAL_WINDOWS - 1);
    localparam logic [WCNT_W-1:0] MAX_WIN     = WCNT_W'(MAX_WINDOWS);
    localparam logic [QCNT_W-1:0] QUIET_END   = QCNT_W'(QUIET_WINDOWS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SUM_W-1:0]  r_acc, r_max, r_suma;
    logic [CVP_W-1:0]  r_cvp;
    logic [SCNT_W-1:0] r_scnt;
    logic [WCNT_W-1:0] r_wcnt;
    logic [QCNT_W-1:0] r_quiet;
    logic              r_armed, r_ce, r_busy, r_cal_done, r_done;

    logic              w_sample_en, w_win_done, w_hi, w_end;
    logic [SUM_W-1:0]  w_sum, w_max_nxt;
    logic [PROD_W-1:0] w_prod;
    logic [CVPR_W-1:0] w_cvp_raw;
    logic [CVP_W-1:0]  w_cvp;
    logic [WCNT_W-1:0] w_wcnt_inc;
    logic [QCNT_W-1:0] w_quiet_inc;

    // Window bookkeeping: the completing sample is folded in combinationally.
    assign w_sample_en = bus.iSampleValid && ((r_state == ST_CAL) || (r_state == ST_MEAS));
    assign w_win_done  = w_sample_en && (r_scnt == LAST_SAMPLE);
    assign w_sum       = r_acc + SUM_W'(bus.ivSample);
    assign w_max_nxt   = (w_sum > r_max) ? w_sum : r_max;
    assign w_wcnt_inc  = r_wcnt + WCNT_W'(1);
    assign w_quiet_inc = r_quiet + QCNT_W'(1);

    // CVP = peak*13/128, clamped to [1, 1023].
    assign w_prod    = PROD_W'(w_max_nxt) * PROD_W'(CVP_MUL);
    assign w_cvp_raw = CVPR_W'(w_prod >> CVP_SHR);

    always_comb begin
        w_cvp = w_cvp_raw[CVP_W-1:0];
        if (w_cvp_raw > CVPR_W'(1023)) begin
            w_cvp = CVP_W'(1023);
        end else if (w_cvp_raw == '0) begin
            w_cvp = CVP_W'(1);
        end
    end

    // Session ends on timeout, or once armed after enough quiet windows.
    assign w_hi  = (w_sum >= SUM_W'(r_cvp));
    assign w_end = (w_wcnt_inc == MAX_WIN) ||
                   (!w_hi && r_armed && (w_quiet_inc == QUIET_END));

    // State register; busy is registered from the next state.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_CAL) || (w_state_nxt == ST_MEAS);
        end
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.iStart) w_state_nxt = ST_CAL;
            ST_CAL:  if (w_win_done && (r_wcnt == LAST_CAL)) w_state_nxt = ST_MEAS;
            ST_MEAS: if (w_win_done && w_end) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.iAbort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Datapath: accumulator, counters, calibration and comparator strobe.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_acc      <= '0;
            r_max      <= '0;
            r_suma     <= '0;
            r_cvp      <= '0;
            r_scnt     <= '0;
            r_wcnt     <= '0;
            r_quiet    <= '0;
            r_armed    <= 1'b0;
            r_ce       <= 1'b0;
            r_cal_done <= 1'b0;
            r_done     <= 1'b0;
        end else if (bus.iAbort) begin
            // Progress dropped; sum, CVP and calibration flag survive.
            r_acc   <= '0;
            r_max   <= '0;
            r_scnt  <= '0;
            r_wcnt  <= '0;
            r_quiet <= '0;
            r_armed <= 1'b0;
            r_ce    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ce   <= 1'b0;
            r_done <= 1'b0;
            if ((r_state == ST_IDLE) && bus.iStart) begin
                r_acc      <= '0;
                r_max      <= '0;
                r_suma     <= '0;
                r_scnt     <= '0;
                r_wcnt     <= '0;
                r_quiet    <= '0;
                r_armed    <= 1'b0;
                r_cal_done <= 1'b0;
            end else if (w_win_done) begin
                r_acc  <= '0;
                r_scnt <= '0;
                r_suma <= w_sum;
                if (r_state == ST_CAL) begin
                    r_max <= w_max_nxt;
                    if (r_wcnt == LAST_CAL) begin
                        r_cvp      <= w_cvp;
                        r_cal_done <= 1'b1;
                        r_wcnt     <= '0;
                    end else begin
                        r_wcnt <= w_wcnt_inc;
                    end
                end else begin
                    r_ce   <= 1'b1;
                    r_done <= w_end;
                    r_wcnt <= w_wcnt_inc;
                    if (w_hi) begin
                        r_armed <= 1'b1;
                        r_quiet <= '0;
                    end else if (r_armed) begin
                        r_quiet <= w_quiet_inc;
                    end
                end
            end else if (w_sample_en) begin
                r_acc  <= w_sum;
                r_scnt <= r_scnt + SCNT_W'(1);
            end
        end
    end

    assign bus.ovSuma   = r_suma;
    assign bus.ovCVP    = r_cvp;
    assign bus.oCE      = r_ce;
    assign bus.oBusy    = r_busy;
    assign bus.oCalDone = r_cal_done;
    assign bus.oDone    = r_done;
    assign bus.ovState  = 3'(r_state);
endmodule

// File: tb/tb_espiro_ctrl.sv
// Purpose : randomized scoreboard bench for espiro_ctrl. The stimulus side
//           predicts every comparator strobe from the window rules and queues
//           it; a negedge monitor pops and compares whenever oCE fires.
module tb_espiro_ctrl;
    localparam int unsigned N    = 16;
    localparam int unsigned CALW = 4;
    localparam int unsigned QW   = 2;
    localparam int unsigned MAXW = 12;

    logic iClk     = 1'b0;
    logic iReset_n = 1'b0;

    espiro_ctrl_if bus();

    espiro_ctrl #(
        .N_SAMPLES    (N),
        .CAL_WINDOWS  (CALW),
        .QUIET_WINDOWS(QW),
        .MAX_WINDOWS  (MAXW)
    ) dut (
        .iClk    (iClk),
        .iReset_n(iReset_n),
        .bus     (bus)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int unsigned suma;
        bit          done;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state for the current session.
    int unsigned m_cvp   = 0;
    int unsigned m_cnt   = 0;
    int unsigned m_quiet = 0;
    bit          m_armed = 1'b0;
    int unsigned last_sum = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Predict one measurement window's comparator result from its sum.
    task automatic model_window(input int unsigned sum, output bit fin);
        m_cnt++;
        if (sum >= m_cvp) begin
            m_armed = 1'b1;
            m_quiet = 0;
        end else if (m_armed) begin
            m_quiet++;
        end
        fin = (m_cnt == MAXW) || (m_armed && (m_quiet == QW));
        sb_q.push_back('{suma: sum, done: fin});
    endtask

    // One valid sample, preceded by 0..2 idle cycles with junk on the bus.
    task automatic send_sample(input int unsigned v, input bit abort_it);
        int unsigned gap;
        gap = $urandom_range(2, 0);
        for (int g = 0; g < int'(gap); g++) begin
            bus.iSampleValid = 1'b0;
            bus.ivSample     = 10'($urandom);
            tick();
        end
        bus.iSampleValid = 1'b1;
        bus.ivSample     = 10'(v);
        bus.iAbort       = abort_it;
        tick();
        bus.iSampleValid = 1'b0;
        bus.iAbort       = 1'b0;
    endtask

    task automatic send_window(input int unsigned lo, input int unsigned hi,
                               input bit meas, output bit fin);
        int unsigned vals[N];
        int unsigned sum;
        sum = 0;
        fin = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            vals[i] = $urandom_range(hi, lo);
            sum += vals[i];
        end
        last_sum = sum;
        if (meas) model_window(sum, fin);
        for (int i = 0; i < int'(N); i++) send_sample(vals[i], 1'b0);
    endtask

    task automatic start_and_cal(input int unsigned lo, input int unsigned hi);
        int unsigned peak;
        bit          unused_fin;
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        check("start_caldone_clr", bus.oCalDone, 0);
        check("start_suma_clr", bus.ovSuma, 0);
        check("start_state_cal", bus.ovState, 1);
        check("start_busy", bus.oBusy, 1);
        peak = 0;
        for (int w = 0; w < int'(CALW); w++) begin
            send_window(lo, hi, 1'b0, unused_fin);
            if (last_sum > peak) peak = last_sum;
        end
        m_cvp = (peak * 13) / 128;
        if (m_cvp > 1023) m_cvp = 1023;
        if (m_cvp == 0) m_cvp = 1;
        m_cnt   = 0;
        m_quiet = 0;
        m_armed = 1'b0;
        check("cal_state_meas", bus.ovState, 2);
        check("cal_done", bus.oCalDone, 1);
        check("cal_cvp", bus.ovCVP, m_cvp);
    endtask

    task automatic after_done();
        tick();
        check("post_done_state_idle", bus.ovState, 0);
        check("post_done_odone_low", bus.oDone, 0);
        check("post_done_busy_low", bus.oBusy, 0);
    endtask

    // Scoreboard monitor: compare on every comparator strobe.
    always @(negedge iClk) begin
        exp_t e;
        if (bus.oCE) begin
            if (sb_q.size() == 0) begin
                check("unexpected_oCE", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("ce_suma", bus.ovSuma, e.suma);
                check("ce_done", bus.oDone, e.done);
                check("ce_cvp", bus.ovCVP, m_cvp);
                check("ce_state", bus.ovState, e.done ? 3 : 2);
            end
        end else if (bus.oDone) begin
            check("oDone_without_oCE", 1, 0);
        end
    end

    initial begin
        bit          fin;
        int unsigned kind;
        bus.iStart       = 1'b0;
        bus.iAbort       = 1'b0;
        bus.iSampleValid = 1'b0;
        bus.ivSample     = '0;

        #1;
        check("rst_suma", bus.ovSuma, 0);
        check("rst_cvp", bus.ovCVP, 0);
        check("rst_state", bus.ovState, 0);
        check("rst_busy", bus.oBusy, 0);
        #22;
        iReset_n = 1'b1;
        tick();

        // Constant flow 500 -> CVP 812, then arm and go quiet.
        start_and_cal(500, 500);
        check("cvp_812", bus.ovCVP, 812);
        send_window(300, 300, 1'b1, fin);
        check("suma_4800", bus.ovSuma, 4800);
        send_window(1000, 1000, 1'b1, fin);
        send_window(0, 0, 1'b1, fin);
        send_window(0, 0, 1'b1, fin);
        check("quiet_end_pred", fin, 1);
        after_done();

        // Saturated calibration and random flow; a stray iStart mid-session.
        start_and_cal(1023, 1023);
        check("cvp_sat", bus.ovCVP, 1023);
        fin = 1'b0;
        for (int w = 0; w < int'(MAXW) && !fin; w++) begin
            if (w == 1) begin
                bus.iStart = 1'b1;
                tick();
                bus.iStart = 1'b0;
            end
            kind = $urandom_range(2, 0);
            case (kind)
                0:       send_window(0, 40, 1'b1, fin);
                1:       send_window(900, 1023, 1'b1, fin);
                default: send_window(0, 1023, 1'b1, fin);
            endcase
        end
        after_done();

        // Zero calibration floors CVP at 1; zero flow never arms -> timeout.
        start_and_cal(0, 0);
        check("cvp_floor", bus.ovCVP, 1);
        fin = 1'b0;
        for (int w = 0; w < int'(MAXW) && !fin; w++) send_window(0, 0, 1'b1, fin);
        check("timeout_windows", m_cnt, MAXW);
        after_done();

        // Abort on the 8th sample of a measurement window.
        start_and_cal(100, 600);
        send_window(200, 800, 1'b1, fin);
        for (int i = 0; i < 7; i++) send_sample($urandom_range(1023, 0), 1'b0);
        send_sample(500, 1'b1);
        check("abort_state", bus.ovState, 0);
        check("abort_odone", bus.oDone, 0);
        check("abort_oce", bus.oCE, 0);
        check("abort_cvp_kept", bus.ovCVP, m_cvp);
        check("abort_caldone_kept", bus.oCalDone, 1);
        check("abort_suma_kept", bus.ovSuma, last_sum);
        for (int i = 0; i < 20; i++) tick();

        // Asynchronous reset in the middle of a measurement window.
        start_and_cal(0, 200);
        send_window(0, 1023, 1'b1, fin);
        for (int i = 0; i < 5; i++) send_sample($urandom_range(1023, 0), 1'b0);
        #2;
        iReset_n = 1'b0;
        #1;
        check("arst_suma", bus.ovSuma, 0);
        check("arst_cvp", bus.ovCVP, 0);
        check("arst_oce", bus.oCE, 0);
        check("arst_busy", bus.oBusy, 0);
        check("arst_caldone", bus.oCalDone, 0);
        check("arst_odone", bus.oDone, 0);
        check("arst_state", bus.ovState, 0);
        @(negedge iClk);
        iReset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("arst_stays_idle", bus.ovState, 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/espiro_ctrl.md
ESPIRO_CTRL -- requirements
Module: espiro_ctrl

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 16, samples per window (power of two, 2..16).
REQ-002 SHALL have parameter CAL_WINDOWS, default 4, windows in calibration phase (1..15).
REQ-003 SHALL have parameter QUIET_WINDOWS, default 2, consecutive below-CVP windows that end a measurement (1..15).
REQ-004 SHALL have parameter MAX_WINDOWS, default 1023, measurement-window timeout (1..1023).
REQ-005 iClk  in  1  single clock, all state on rising edge.
REQ-006 iReset_n  in  1  reset, asynchronous, active-low.
REQ-007 iStart  in  1  starts a session, sampled only in IDLE.
REQ-008 iAbort  in  1  forces return to IDLE.
REQ-009 iSampleValid  in  1  ivSample valid this cycle.
REQ-010 ivSample  in  10  unsigned ADC flow sample.
REQ-011 ovSuma  out  14  last completed window sum, to comparator sum input.
REQ-012 ovCVP  out  10  calibrated per-level step, to comparator CVP input.
REQ-013 oCE  out  1  one-cycle comparator enable strobe.
REQ-014 oBusy  out  1  high in CAL or MEAS.
REQ-015 oCalDone  out  1  high once calibration completes, until next iStart or reset.
REQ-016 oDone  out  1  one-cycle end-of-session pulse.
REQ-017 ovState  out  3  IDLE=0, CAL=1, MEAS=2, DONE=3.

Function
REQ-018 SHALL implement states IDLE, CAL, MEAS, DONE; IDLE->CAL on iStart; CAL->MEAS after CAL_WINDOWS windows; MEAS->DONE on end condition; DONE->IDLE unconditionally next cycle.
REQ-019 SHALL accumulate ivSample into a 14-bit accumulator only in CAL/MEAS and only when iSampleValid; a window completes on the edge of its N_SAMPLES-th valid sample (max 16*1023=16368, no overflow).
REQ-020 SHALL, on window completion, load the completed sum (accumulator plus current sample) into ovSuma and clear the accumulator in the same edge; the next valid sample starts the next window.
REQ-021 SHALL in CAL track the maximum window sum over CAL_WINDOWS windows; on last CAL window compute CVP = (max*13)>>7 with 18-bit intermediate, saturate to 1023, floor at 1, load ovCVP and set oCalDone in the same edge.
REQ-022 SHALL hold ovCVP constant through MEAS and DONE; ovCVP only changes at CAL completion or reset.
REQ-023 SHALL assert oCE for exactly one cycle, the cycle after each MEAS window completion, with ovSuma already stable; oCE SHALL never assert in IDLE, CAL or DONE.
REQ-024 SHALL count MEAS windows; once any MEAS window sum >= ovCVP (armed), QUIET_WINDOWS consecutive windows with sum < ovCVP end the session; a window >= ovCVP resets the quiet count.
REQ-025 SHALL end the session when MAX_WINDOWS MEAS windows complete, regardless of armed state.
REQ-026 SHALL, when the ending window completes, still issue its oCE in the next cycle, which coincides with DONE and oDone=1 (sole exception to REQ-023 for DONE).
REQ-027 SHALL give iAbort priority over all events: next state IDLE, accumulator, window/quiet counters and pending oCE cleared, no oDone; ovSuma, ovCVP, oCalDone retained.
REQ-028 SHALL ignore iStart outside IDLE; iStart in IDLE clears oCalDone, ovSuma and counters.
REQ-029 SHALL discard iSampleValid in IDLE and DONE.

Reset
REQ-030 SHALL on iReset_n low, asynchronously: state IDLE, ovSuma=0, ovCVP=0, oCE=0, oBusy=0, oCalDone=0, oDone=0, all counters/accumulator/max cleared.
REQ-031 SHALL release reset synchronously to iClk; reset mid-session discards all progress.

Verification
REQ-032 Reset asserted mid-MEAS -> all outputs 0 immediately without clock edge, ovState=0.
REQ-033 iStart, 64 valid samples of 500 (defaults) -> max 8000, ovCVP=812, oCalDone=1, ovState=2 after 64th sample edge; no oCE.
REQ-034 Calibration with samples 1023 -> ovCVP=1023 (saturated); with samples 0 -> ovCVP=1.
REQ-035 MEAS, ovCVP=812, 16 samples of 300 -> ovSuma=4800 on 16th-sample edge, oCE=1 exactly next cycle only.
REQ-036 MEAS: window of 1000s (16000, armed), then two windows of 0 -> second zero window gives oCE and oDone together next cycle, then ovState=0.
REQ-037 iAbort during 8th sample of a MEAS window -> ovState=0 next edge, no oCE, no oDone, ovCVP unchanged.
